// File: rtl/pifo_sorted_queue.sv
// pifo_sorted_queue: insertion-sorted PIFO with priority eviction and backpressured drop port
module pifo_sorted_queue #(
  parameter int DEPTH = 16,
  parameter int BITPRIO = 16,
  parameter int BITDESC = 32,
  parameter int DROP_THRESH = DEPTH - 2,
  parameter int BITCNT = 32,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pifo_in_valid,
  output logic               pifo_in_ready,
  input  logic [BITPRIO-1:0] pifo_in_prio,
  input  logic [BITDESC-1:0] pifo_in_data,
  input  logic               pifo_in_drop,
  output logic               pifo_out_valid,
  input  logic               pifo_out_ready,
  output logic [BITPRIO-1:0] pifo_out_prio,
  output logic [BITDESC-1:0] pifo_out_data,
  output logic               pifo_out_drop_valid,
  input  logic               pifo_out_drop_ready,
  output logic [BITPRIO-1:0] pifo_out_drop_prio,
  output logic [BITDESC-1:0] pifo_out_drop_data,
  output logic [CW-1:0]      pifo_count,
  output logic [BITCNT-1:0]  pifo_drop_count
);
  localparam logic [CW-1:0] LIM_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LIM_SOFT = CW'(DROP_THRESH);
  logic [BITPRIO-1:0] prio [DEPTH];
  logic [BITDESC-1:0] data [DEPTH];
  logic [BITPRIO-1:0] sp [DEPTH];
  logic [BITDESC-1:0] sd [DEPTH];
  logic [BITPRIO-1:0] np [DEPTH];
  logic [BITDESC-1:0] nd [DEPTH];
  logic [DEPTH-1:0]   le;
  logic [CW-1:0]      cnt, e, lim, ncnt;
  logic [BITPRIO-1:0] last_p;
  logic [BITDESC-1:0] last_d;
  logic               pop, push, full, evict, drop_in, ins;
  assign pifo_in_ready  = !pifo_out_drop_valid || pifo_out_drop_ready;
  assign pifo_out_valid = cnt != '0;
  assign pifo_out_prio  = prio[0];
  assign pifo_out_data  = data[0];
  assign pifo_count     = cnt;
  // Pop-shifted view of the array, push decision and next-state array with sorted insert
  always_comb begin
    pop = pifo_out_ready && cnt != '0;
    push = pifo_in_valid && pifo_in_ready;
    e = cnt - CW'(pop);
    lim = pifo_in_drop ? LIM_SOFT : LIM_FULL;
    for (int i = 0; i < DEPTH - 1; i++) begin
      sp[i] = pop ? prio[i+1] : prio[i];
      sd[i] = pop ? data[i+1] : data[i];
    end
    sp[DEPTH-1] = prio[DEPTH-1];
    sd[DEPTH-1] = data[DEPTH-1];
    last_p = sp[0];
    last_d = sd[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == e - 1'b1) begin
        last_p = sp[i];
        last_d = sd[i];
      end
      le[i] = CW'(i) < e && sp[i] <= pifo_in_prio;
    end
    full = e >= lim;
    evict = push && full && pifo_in_prio < last_p;
    drop_in = push && full && !evict;
    ins = push && !drop_in;
    np[0] = (!ins || le[0]) ? sp[0] : pifo_in_prio;
    nd[0] = (!ins || le[0]) ? sd[0] : pifo_in_data;
    for (int i = 1; i < DEPTH; i++) begin
      np[i] = (!ins || le[i]) ? sp[i] : le[i-1] ? pifo_in_prio : sp[i-1];
      nd[i] = (!ins || le[i]) ? sd[i] : le[i-1] ? pifo_in_data : sd[i-1];
    end
    ncnt = (ins && !evict) ? e + 1'b1 : e;
  end
  // Entry array, occupancy, drop register and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      pifo_out_drop_valid <= 1'b0;
      pifo_drop_count <= '0;
    end else begin
      cnt <= ncnt;
      prio <= np;
      data <= nd;
      if (drop_in || evict) begin
        pifo_out_drop_valid <= 1'b1;
        pifo_out_drop_prio <= evict ? last_p : pifo_in_prio;
        pifo_out_drop_data <= evict ? last_d : pifo_in_data;
        if (!(&pifo_drop_count)) pifo_drop_count <= pifo_drop_count + 1'b1;
      end else if (pifo_out_drop_ready) begin
        pifo_out_drop_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pifo_sorted_queue.sv
// tb_pifo_sorted_queue: directed and random checks of the PIFO against a queue-based model
module tb_pifo_sorted_queue;
  localparam int DEPTH = 4;
  localparam int BP = 8;
  localparam int BD = 16;
  localparam int TH = 2;
  localparam int BC = 4;
  localparam int CW = $clog2(DEPTH) + 1;
  typedef struct packed {
    logic [BP-1:0] p;
    logic [BD-1:0] d;
  } ent_t;
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_ready, in_drop = 0;
  logic [BP-1:0] in_prio = 0;
  logic [BD-1:0] in_data = 0;
  logic out_valid, out_ready = 0;
  logic [BP-1:0] out_prio, drop_prio;
  logic [BD-1:0] out_data, drop_data;
  logic drop_valid, drop_ready = 0;
  logic [CW-1:0] count;
  logic [BC-1:0] drop_count;
  int vectors = 0, errs = 0;
  ent_t mq[$];
  logic mdv = 0;
  ent_t mdr;
  int mdc = 0;
  always #5 clk = ~clk;
  pifo_sorted_queue #(.DEPTH(DEPTH), .BITPRIO(BP), .BITDESC(BD), .DROP_THRESH(TH), .BITCNT(BC)) dut (
    .clk(clk), .rst(rst),
    .pifo_in_valid(in_valid), .pifo_in_ready(in_ready), .pifo_in_prio(in_prio),
    .pifo_in_data(in_data), .pifo_in_drop(in_drop),
    .pifo_out_valid(out_valid), .pifo_out_ready(out_ready),
    .pifo_out_prio(out_prio), .pifo_out_data(out_data),
    .pifo_out_drop_valid(drop_valid), .pifo_out_drop_ready(drop_ready),
    .pifo_out_drop_prio(drop_prio), .pifo_out_drop_data(drop_data),
    .pifo_count(count), .pifo_drop_count(drop_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0; drop_ready = 0; in_drop = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    mq.delete();
    mdv = 0;
    mdc = 0;
  endtask
  task automatic cycle(input logic v, input logic [BP-1:0] p, input logic [BD-1:0] d,
                       input logic dr, input logic ordy, input logic drdy);
    logic push, pop, dropped;
    ent_t n, lost;
    int idx, lim;
    in_valid = v; in_prio = p; in_data = d; in_drop = dr; out_ready = ordy; drop_ready = drdy;
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("head_prio", 32'(out_prio), 32'(mq[0].p));
      chk("head_data", 32'(out_data), 32'(mq[0].d));
    end
    chk("drop_valid", 32'(drop_valid), 32'(mdv));
    if (mdv) begin
      chk("drop_prio", 32'(drop_prio), 32'(mdr.p));
      chk("drop_data", 32'(drop_data), 32'(mdr.d));
    end
    chk("drop_count", 32'(drop_count), 32'(mdc));
    chk("in_ready", 32'(in_ready), 32'(!mdv || drdy));
    push = v && (!mdv || drdy);
    pop = ordy && mq.size() != 0;
    dropped = 0;
    n = '{p: p, d: d};
    if (pop) void'(mq.pop_front());
    if (push) begin
      lim = dr ? TH : DEPTH;
      idx = 0;
      foreach (mq[i]) if (mq[i].p <= p) idx++;
      if (mq.size() < lim) mq.insert(idx, n);
      else if (p < mq[$].p) begin
        lost = mq.pop_back();
        mq.insert(idx, n);
        dropped = 1;
      end else begin
        lost = n;
        dropped = 1;
      end
    end
    if (dropped) begin
      mdv = 1;
      mdr = lost;
      if (mdc < (1 << BC) - 1) mdc++;
    end else if (drdy) mdv = 0;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    do_reset();
    cycle(0, 0, 0, 0, 0, 1);
    // sort order with equal-priority FIFO ordering, then drain
    cycle(1, 30, 16'h0a01, 0, 0, 1);
    cycle(1, 10, 16'h0a02, 0, 0, 1);
    cycle(1, 20, 16'h0a03, 0, 0, 1);
    cycle(1, 10, 16'h0a04, 0, 0, 1);
    chk("t1_full", 32'(count), 32'd4);
    chk("t1_head_first10", 32'(out_data), 32'h0a02);
    cycle(0, 0, 0, 0, 1, 1);
    chk("t1_head_second10", 32'(out_data), 32'h0a04);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 1, 1);
    chk("t1_empty", 32'(out_valid), 32'd0);
    cycle(0, 0, 0, 0, 1, 1);
    // full queue: worse priority dropped, better priority evicts tail
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(1, 8'(i), 16'(16'h0b00 + i), 0, 0, 1);
    cycle(1, 9, 16'h0b09, 0, 0, 0);
    chk("t2_drop_prio", 32'(drop_prio), 32'd9);
    chk("t2_drop_count", 32'(drop_count), 32'd1);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 1, 16'h0b01, 0, 0, 0);
    chk("t3_evict_prio", 32'(drop_prio), 32'd8);
    chk("t3_head", 32'(out_prio), 32'd1);
    chk("t3_count", 32'(count), 32'd4);
    cycle(0, 0, 0, 0, 0, 1);
    // soft threshold
    do_reset();
    cycle(1, 5, 16'h0c05, 0, 0, 1);
    cycle(1, 6, 16'h0c06, 0, 0, 1);
    cycle(1, 7, 16'h0c07, 1, 0, 1);
    chk("t4_soft_drop", 32'(drop_valid), 32'd1);
    cycle(1, 7, 16'h0c17, 0, 0, 1);
    chk("t4_insert", 32'(count), 32'd3);
    cycle(0, 0, 0, 0, 0, 1);
    // simultaneous pop of head and push of a better priority on a full queue
    do_reset();
    for (int i = 5; i <= 8; i++) cycle(1, 8'(i), 16'(16'h0d00 + i), 0, 0, 1);
    cycle(1, 3, 16'h0d03, 0, 1, 1);
    chk("t5_head", 32'(out_prio), 32'd3);
    chk("t5_nodrop", 32'(drop_valid), 32'd0);
    cycle(0, 0, 0, 0, 0, 1);
    // held drop port backpressures input; reset mid-stream
    cycle(1, 9, 16'h0e09, 0, 0, 0);
    cycle(1, 10, 16'h0e0a, 0, 0, 0);
    cycle(1, 11, 16'h0e0b, 0, 0, 0);
    cycle(1, 11, 16'h0e0b, 0, 0, 1);
    cycle(1, 12, 16'h0e0c, 0, 0, 0);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    mq.delete();
    mdv = 0;
    mdc = 0;
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_drop_valid", 32'(drop_valid), 32'd0);
    chk("t6_rst_drop_count", 32'(drop_count), 32'd0);
    cycle(0, 0, 0, 0, 1, 1);
    // random traffic, includes drop-counter saturation
    for (int k = 0; k < 3000; k++)
      cycle(1'($urandom_range(0, 3) != 0), 8'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/pifo_sorted_queue.md
Name: pifo_sorted_queue

Overview:
- Single-clock, parametrised priority queue (PIFO) storing full descriptors in an insertion-sorted register array.
- Generalises the descriptor-PIFO wrapper used ahead of schedulers:
  - no clock crossing;
  - configurable depth and widths;
  - priority-based eviction on overflow, routed to a backpressured drop port;
  - optional soft drop threshold;
  - drop statistics.
- Sits between classifier output and the scheduler/egress arbiter.

Parameters:
- DEPTH, 16, number of entries (≥2).
- BITPRIO, 16, priority width; lower value = served first.
- BITDESC, 32, descriptor width.
- DROP_THRESH, DEPTH-2, occupancy at which pifo_in_drop forces drop/evict (1..DEPTH).
- BITCNT, 32, drop-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pifo_in_valid  in  1  push request.
- pifo_in_ready  out  1  push accepted when valid&&ready.
- pifo_in_prio  in  BITPRIO  push priority.
- pifo_in_data  in  BITDESC  push descriptor.
- pifo_in_drop  in  1  soft-drop enable (congestion hint), sampled on push.
- pifo_out_valid  out  1  head entry present.
- pifo_out_ready  in  1  pop when valid&&ready.
- pifo_out_prio  out  BITPRIO  head priority.
- pifo_out_data  out  BITDESC  head descriptor.
- pifo_out_drop_valid  out  1  dropped/evicted entry held.
- pifo_out_drop_ready  in  1  drop port accept.
- pifo_out_drop_prio  out  BITPRIO  dropped priority.
- pifo_out_drop_data  out  BITDESC  dropped descriptor.
- pifo_count  out  $clog2(DEPTH)+1  current occupancy.
- pifo_drop_count  out  BITCNT  total drops+evictions, saturating.

Behaviour:
- Reset values:
  - count = 0, so pifo_out_valid = 0;
  - pifo_out_drop_valid = 0;
  - pifo_drop_count = 0.
  - Entry contents are don't-care.
  - Reset mid-operation discards all entries and any pending drop with no drop reported.
- Storage:
  - entries 0..count-1 are valid, sorted ascending by prio;
  - entry 0 is the head.
  - Equal priorities are kept in arrival order: the insert position is the number of valid entries with prio ≤ new prio.
- Output:
  - pifo_out_valid = (count != 0);
  - prio/data driven directly from entry 0, zero-latency from registers.
  - Pop (valid&&ready): entries shift toward head, count-1.
  - ready with count==0 has no effect.
- pifo_in_ready = !pifo_out_drop_valid || pifo_out_drop_ready.
  - The drop register therefore never loses an entry.
  - Independent of occupancy: a full queue never backpressures; overflow goes to drop.
- Push decision (evaluated on the pre-cycle array):
  - Effective occupancy E = count - pop.
  - Limit L = DROP_THRESH if pifo_in_drop, else DEPTH.
  - E < L: insert, count+1-pop.
  - E ≥ L:
    - if in_prio < prio of last valid entry (after pop), insert and evict that last entry into the drop register; count unchanged-pop.
    - Otherwise the incoming descriptor goes to the drop register.
- Simultaneous push+pop:
  - pop removes the old head;
  - insert position is computed against the remaining entries;
  - a new entry with prio below the old head becomes the new head the next cycle (it is not popped in the same cycle).
- Drop register:
  - loaded on any drop/evict, drop_valid = 1 the next cycle;
  - cleared on drop_ready unless reloaded the same cycle.
- pifo_drop_count increments by 1 per drop/evict and saturates at all-ones.
- Latency: pushed entry visible on pifo_out_* the cycle after acceptance if it is the head.

Test Plan:
- DEPTH=4: push prio 30,10,20,10(b) → pops in order 10,10(b),20,30; count 4→0; out_valid drops after the 4th pop.
- Full {5,6,7,8}, push prio 9 → drop port shows 9 next cycle, queue unchanged, drop_count=1.
- Full {5,6,7,8}, push prio 1 → 8 evicted to drop port, head becomes 1, count stays 4.
- DROP_THRESH=2, count=2 {5,6}, pifo_in_drop=1, push prio 7 → 7 dropped; with pifo_in_drop=0, push prio 7 → inserted, count=3.
- Full, same cycle pop (head 5) + push prio 3 → head 3 next cycle, no drop, count 4.
- Hold drop_ready=0 after a drop → pifo_in_ready=0 until drop_ready=1; no second drop lost; assert rst mid-stream → count=0, drop_valid=0, drop_count=0.
